// File: rtl/bcd_scan_pkg.sv
// bcd_scan_pkg
// Shared constants and helpers for the 4-digit BCD scan driver.
//   DIGITS  : number of display digits scanned
//   AN_OFF  : digit-enable pattern with every digit dark (active-low enables)
//   BCD_MAX : largest legal BCD nibble value
//   nib()   : selects the nibble of a packed 4-digit value addressed by a digit index
package bcd_scan_pkg;

    localparam int          DIGITS  = 4;
    localparam logic [3:0]  AN_OFF  = 4'b1111;
    localparam logic [3:0]  BCD_MAX = 4'd9;

    function automatic logic [3:0] nib(input logic [15:0] shd, input logic [1:0] idx);
        return shd[{idx, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/bcd_scan_tick.sv
// bcd_scan_tick
// Prescaler that paces the digit scan. The counter runs 0..CLK_DIV-1 and
// wraps; tick is high for the single cycle in which the count is at its top.
// Ports:
//   clk  : system clock
//   rst  : synchronous active-high reset (count returns to 0)
//   tick : one-cycle pulse, once every CLK_DIV cycles
module bcd_scan_tick #(
    parameter int CLK_DIV = 50000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        tick  = (cnt_q == CW'(CLK_DIV - 1));
        cnt_d = tick ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/bcd_scan_mux.sv
// bcd_scan_mux
// Time-multiplexed scan driver for a 4-digit common-anode 7-segment display.
// Presents one digit at a time to the downstream bcd_dec decoder together
// with the matching active-low digit enable, adding leading-zero blanking,
// invalid-digit flagging and a one-cycle dark gap at every digit change.
// Ports:
//   clk       : system clock
//   rst       : synchronous active-high reset
//   digits_in : packed BCD value, [3:0] is digit 0 (rightmost)
//   load      : capture digits_in into the shadow register this edge
//   blank_lz  : enable leading-zero blanking (sampled every cycle)
//   bcd       : BCD nibble of the selected digit (driven even when dark)
//   an        : active-low digit enables, an[i] drives digit i
//   blank     : high when no digit is lit (gap, zero-blanked or invalid)
//   err       : high while the selected digit holds a nibble above 9
module bcd_scan_mux
    import bcd_scan_pkg::*;
#(
    parameter int CLK_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] digits_in,
    input  logic        load,
    input  logic        blank_lz,
    output logic [3:0]  bcd,
    output logic [3:0]  an,
    output logic        blank,
    output logic        err
);

    logic        tick;

    logic [15:0] shd_q,   shd_d;
    logic [1:0]  idx_q,   idx_d;
    logic        gap_q,   gap_d;

    logic [3:0]  bcd_q,   bcd_d;
    logic [3:0]  an_q,    an_d;
    logic        blank_q, blank_d;
    logic        err_q,   err_d;

    logic [3:0]  n;
    logic        invalid;
    logic        lz;
    logic        off;

    // zero_from[i] is high when digit i and every digit above it are zero,
    // i.e. digit i would be a leading zero.
    logic [DIGITS-1:0] zero_from;

    bcd_scan_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_zero_from
            assign zero_from[gi] = ~|shd_q[4*DIGITS-1 : 4*gi];
        end
    endgenerate

    // Scan state: the digit index advances on tick, and the gap flag marks
    // the first output cycle of each new slot as dark. A load replaces the
    // shadow value without touching the scan position.
    always_comb begin
        shd_d = load ? digits_in : shd_q;
        idx_d = tick ? idx_q + 2'd1 : idx_q;
        gap_d = tick;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shd_q <= 16'h0000;
            idx_q <= 2'd0;
            gap_q <= 1'b1;
        end else begin
            shd_q <= shd_d;
            idx_q <= idx_d;
            gap_q <= gap_d;
        end
    end

    // Output decode from the current scan state. Digit 0 is never
    // zero-blanked so an all-zero value still shows a single 0.
    always_comb begin
        n       = nib(shd_q, idx_q);
        invalid = (n > BCD_MAX);
        lz      = blank_lz && (idx_q != 2'd0) && zero_from[idx_q];
        off     = gap_q || lz || invalid;

        bcd_d   = n;
        an_d    = off ? AN_OFF : ~(4'b0001 << idx_q);
        blank_d = off;
        // An invalid nibble is not reported during the gap cycle, so err
        // lines up with the cycles the digit would otherwise be lit.
        err_d   = invalid && !gap_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bcd_q   <= 4'h0;
            an_q    <= AN_OFF;
            blank_q <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            bcd_q   <= bcd_d;
            an_q    <= an_d;
            blank_q <= blank_d;
            err_q   <= err_d;
        end
    end

    assign bcd   = bcd_q;
    assign an    = an_q;
    assign blank = blank_q;
    assign err   = err_q;

endmodule

// File: tb/tb_bcd_scan_mux.sv
// tb_bcd_scan_mux
// Self-checking bench for bcd_scan_mux with CLK_DIV=4. A cycle model pushes
// the expected outputs for every driven cycle into a queue which is popped
// and compared after the edge; a vector table of hand-derived per-digit
// expectations and a few hand-written sequences cover the scan scenarios.
module tb_bcd_scan_mux;

    localparam int CLK_DIV = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] digits_in = 16'h0000;
    logic        load = 1'b0;
    logic        blank_lz = 1'b0;
    logic [3:0]  bcd;
    logic [3:0]  an;
    logic        blank;
    logic        err;

    always #5 clk = ~clk;

    bcd_scan_mux #(
        .CLK_DIV (CLK_DIV)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .digits_in (digits_in),
        .load      (load),
        .blank_lz  (blank_lz),
        .bcd       (bcd),
        .an        (an),
        .blank     (blank),
        .err       (err)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        logic [3:0] an;
        logic [3:0] bcd;
        logic       blank;
        logic       err;
    } exp_t;

    exp_t sb_q[$];

    // Spec-level model state
    int          m_cnt = 0;
    logic [1:0]  m_idx = 2'd0;
    logic        m_gap = 1'b1;
    logic [15:0] m_shd = 16'h0000;

    // Table of hand-derived per-digit expectations; nibble i of each packed
    // field is the value for digit i while it is lit (or blanked).
    typedef struct {
        logic [15:0] val;
        logic        blz;
        logic [15:0] an_all;
        logic [15:0] bcd_all;
        logic [3:0]  blank_all;
        logic [3:0]  err_all;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, req);
        end
    endtask

    function automatic exp_t model_out(input logic r, input logic blz);
        exp_t       e;
        logic [3:0] nv;
        logic       inv, lzb, dark;
        if (r) begin
            e.an = 4'b1111; e.bcd = 4'h0; e.blank = 1'b1; e.err = 1'b0;
        end else begin
            nv   = m_shd[int'(m_idx)*4 +: 4];
            inv  = (nv > 4'd9);
            lzb  = blz && (m_idx != 2'd0) && ((m_shd >> (int'(m_idx)*4)) == 16'h0000);
            dark = m_gap || lzb || inv;
            e.bcd   = nv;
            e.an    = dark ? 4'b1111 : ~(4'b0001 << m_idx);
            e.blank = dark;
            e.err   = inv && !m_gap;
        end
        return e;
    endfunction

    task automatic model_advance(input logic r, input logic ld, input logic [15:0] d);
        logic t;
        if (r) begin
            m_cnt = 0; m_idx = 2'd0; m_gap = 1'b1; m_shd = 16'h0000;
        end else begin
            t     = (m_cnt == CLK_DIV - 1);
            m_gap = t;
            if (t) m_idx = m_idx + 2'd1;
            m_cnt = t ? 0 : m_cnt + 1;
            if (ld) m_shd = d;
        end
    endtask

    // One clock transaction: drive, predict, clock, compare.
    task automatic step(input logic r, input logic ld, input logic [15:0] d, input logic blz);
        exp_t e;
        int   lows;
        rst       = r;
        load      = ld;
        digits_in = d;
        blank_lz  = blz;
        sb_q.push_back(model_out(r, blz));
        model_advance(r, ld, d);
        @(posedge clk);
        #1;
        cyc++;
        if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_empty cyc=%0d actual=0 required=1", cyc);
        end else begin
            e = sb_q.pop_front();
            check("sb_an",    {12'h0, an},    {12'h0, e.an});
            check("sb_bcd",   {12'h0, bcd},   {12'h0, e.bcd});
            check("sb_blank", {15'h0, blank}, {15'h0, e.blank});
            check("sb_err",   {15'h0, err},   {15'h0, e.err});
        end
        lows = 0;
        for (int i = 0; i < 4; i++) if (an[i] == 1'b0) lows++;
        check("an_onehot", (lows <= 1) ? 16'h1 : 16'h0, 16'h1);
        $display("cyc=%0d rst=%b load=%b din=%h blz=%b -> an=%b bcd=%h blank=%b err=%b",
                 cyc, r, ld, d, blz, an, bcd, blank, err);
    endtask

    initial begin
        vecs[0] = '{16'h1234, 1'b0, 16'h7BDE, 16'h1234, 4'b0000, 4'b0000};
        vecs[1] = '{16'h0042, 1'b1, 16'hFFDE, 16'h0042, 4'b1100, 4'b0000};
        vecs[2] = '{16'h0000, 1'b1, 16'hFFFE, 16'h0000, 4'b1110, 4'b0000};
        vecs[3] = '{16'h12A4, 1'b0, 16'h7BFE, 16'h12A4, 4'b0010, 4'b0010};
        vecs[4] = '{16'h0042, 1'b0, 16'h7BDE, 16'h0042, 4'b0000, 4'b0000};
        vecs[5] = '{16'hF009, 1'b1, 16'hFBDE, 16'hF009, 4'b1000, 4'b1000};

        // Reset state
        step(1'b1, 1'b0, 16'h0000, 1'b0);
        check("rst_an",    {12'h0, an},    16'h000F);
        check("rst_bcd",   {12'h0, bcd},   16'h0000);
        check("rst_blank", {15'h0, blank}, 16'h0001);
        check("rst_err",   {15'h0, err},   16'h0000);

        // Reset then idle: two dark cycles, digit 0 lit showing 0 for 3 cycles
        for (int k = 1; k <= 8; k++) begin
            step(1'b0, 1'b0, 16'h0000, 1'b0);
            if (k == 1 || k == 5) check("idle_dark_an", {12'h0, an}, 16'h000F);
            else if (k <= 4) begin
                check("idle_d0_an",  {12'h0, an},  16'h000E);
                check("idle_d0_bcd", {12'h0, bcd}, 16'h0000);
            end
        end

        // Vector table: reset, load at the first edge, then one full refresh
        foreach (vecs[v]) begin
            step(1'b1, 1'b0, 16'h0000, vecs[v].blz);
            for (int k = 1; k <= 4 * CLK_DIV; k++) begin
                int p, dg;
                step(1'b0, k == 1, vecs[v].val, vecs[v].blz);
                p  = k - 1;
                dg = p / CLK_DIV;
                if (p % CLK_DIV == 0) begin
                    check("vec_gap_an",    {12'h0, an},    16'h000F);
                    check("vec_gap_blank", {15'h0, blank}, 16'h0001);
                    check("vec_gap_err",   {15'h0, err},   16'h0000);
                end else begin
                    check("vec_an",    {12'h0, an},    {12'h0, vecs[v].an_all[dg*4 +: 4]});
                    check("vec_bcd",   {12'h0, bcd},   {12'h0, vecs[v].bcd_all[dg*4 +: 4]});
                    check("vec_blank", {15'h0, blank}, {15'h0, vecs[v].blank_all[dg]});
                    check("vec_err",   {15'h0, err},   {15'h0, vecs[v].err_all[dg]});
                end
            end
        end

        // Load mid-slot while digit 1 is lit: value changes, timing does not
        step(1'b1, 1'b0, 16'h0000, 1'b0);
        for (int k = 1; k <= 10; k++) begin
            step(1'b0, (k == 1) || (k == 6), (k == 1) ? 16'h1234 : 16'h5678, 1'b0);
            case (k)
                6:  check("mid_before_bcd", {12'h0, bcd}, 16'h0003);
                7:  begin
                        check("mid_after_bcd", {12'h0, bcd}, 16'h0007);
                        check("mid_after_an",  {12'h0, an},  16'h000D);
                    end
                8:  check("mid_tail_bcd", {12'h0, bcd}, 16'h0007);
                9:  check("mid_gap_an",   {12'h0, an},  16'h000F);
                10: begin
                        check("mid_next_an",  {12'h0, an},  16'h000B);
                        check("mid_next_bcd", {12'h0, bcd}, 16'h0006);
                    end
                default: ;
            endcase
        end

        // Reset (with a simultaneous load) while digit 2 is lit
        step(1'b1, 1'b0, 16'h0000, 1'b0);
        for (int k = 1; k <= 9; k++) step(1'b0, k == 1, 16'h1234, 1'b0);
        check("pre_rst_an", {12'h0, an}, 16'h000F);
        step(1'b0, 1'b0, 16'h0000, 1'b0);
        check("pre_rst_d2_an", {12'h0, an}, 16'h000B);
        step(1'b1, 1'b1, 16'h9999, 1'b0);
        check("mrst_an",  {12'h0, an},  16'h000F);
        check("mrst_bcd", {12'h0, bcd}, 16'h0000);
        check("mrst_err", {15'h0, err}, 16'h0000);
        for (int k = 1; k <= 5; k++) begin
            step(1'b0, 1'b0, 16'h0000, 1'b0);
            if (k == 1 || k == 5) check("mrst_dark_an", {12'h0, an}, 16'h000F);
            else begin
                check("mrst_d0_an",  {12'h0, an},  16'h000E);
                check("mrst_d0_bcd", {12'h0, bcd}, 16'h0000);
            end
        end

        // blank_lz released mid-slot on a zero-blanked digit
        step(1'b1, 1'b0, 16'h0000, 1'b1);
        for (int k = 1; k <= 12; k++) begin
            step(1'b0, k == 1, 16'h0042, k < 11);
            if (k == 10) check("lz_blanked_an", {12'h0, an}, 16'h000F);
            if (k == 11) begin
                check("lz_release_an",    {12'h0, an},    16'h000B);
                check("lz_release_blank", {15'h0, blank}, 16'h0000);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
